pc_sequencer: RTL

- Parametrised program-counter sequencer for the MIPS-style datapath.
- Registers the PC and builds the next PC internally: sequential step, sign-extended and shifted branch offset, region jump, and register jump.
- Adds stall handling with a one-entry pending-redirect buffer, a one-cycle flush pulse, and alignment checking of register-jump targets.
- Sits between instruction fetch and the branch/jump resolution logic.

---
 rtl/pc_sequencer.sv | 73 +++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with branch/jump/jr targets,
// stall-time redirect buffering, flush pulse and jr alignment error.
module pc_sequencer #(
    parameter int WIDTH      = 32,
    parameter int IMM_WIDTH  = 16,
    parameter int JIMM_WIDTH = 26,
    parameter int SHIFT      = 2,
    parameter int STEP       = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  br_taken,
    input  logic [IMM_WIDTH-1:0]  br_imm,
    input  logic                  jmp,
    input  logic [JIMM_WIDTH-1:0] jmp_idx,
    input  logic                  jr,
    input  logic [WIDTH-1:0]      jr_addr,
    output logic [WIDTH-1:0]      pc,
    output logic [WIDTH-1:0]      pc_step,
    output logic                  flush,
    output logic                  align_err,
    output logic                  pend
);
    typedef enum logic [1:0] {RUN, HOLD, HOLD_PEND} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d, buf_q, buf_d;
    logic             flush_q, flush_d, align_q, align_d;
    logic             redir;
    logic [WIDTH-1:0] br_target, jmp_target, jr_target, redir_target;

    assign pc_step    = pc_q + WIDTH'(STEP);
    assign br_target  = pc_step + ({{(WIDTH-IMM_WIDTH){br_imm[IMM_WIDTH-1]}}, br_imm} << SHIFT);
    assign jmp_target = {pc_step[WIDTH-1:JIMM_WIDTH+SHIFT], jmp_idx, {SHIFT{1'b0}}};
    assign jr_target  = {jr_addr[WIDTH-1:SHIFT], {SHIFT{1'b0}}};
    assign redir      = jr | jmp | br_taken;
    assign redir_target = jr ? jr_target : jmp ? jmp_target : br_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
            flush_q <= 1'b0;
            align_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            flush_q <= flush_d;
            align_q <= align_d;
        end
    end

    // RUN and HOLD differ only in name; any stalled redirect parks in HOLD_PEND
    always_comb begin
        state_d = !stall ? RUN : (redir || state_q == HOLD_PEND) ? HOLD_PEND : HOLD;
    end

    always_comb begin
        pc_d    = stall ? pc_q : redir ? redir_target : (state_q == HOLD_PEND) ? buf_q : pc_step;
        buf_d   = (stall && redir) ? redir_target : buf_q;
        flush_d = !stall && (redir || state_q == HOLD_PEND);
        align_d = jr && (jr_addr[SHIFT-1:0] != '0);
    end

    assign pc        = pc_q;
    assign flush     = flush_q;
    assign align_err = align_q;
    assign pend      = (state_q == HOLD_PEND);
endmodule
